// File: rtl/word_pkg.sv
// Shared constants and the per-channel state encoding for the word packing/unpacking blocks.
package word_pkg;

    localparam int BYTE_W = 8;
    localparam int NBYTES = 4;
    localparam int WORD_W = BYTE_W * NBYTES;

    typedef enum logic {
        IDLE = 1'b0,
        SEND = 1'b1
    } state_t;

endpackage : word_pkg

// File: rtl/unpack_channel.sv
// One unpacking lane: latches a packed word and streams it out MSB byte first
// over a valid/ready byte interface.
module unpack_channel #(
    parameter int BYTE_W = word_pkg::BYTE_W,
    parameter int NBYTES = word_pkg::NBYTES
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic [BYTE_W*NBYTES-1:0] word_in,
    input  logic                     word_valid,
    output logic                     word_ready,
    output logic [BYTE_W-1:0]        byte_out,
    output logic                     byte_valid,
    input  logic                     byte_ready,
    output logic                     busy
);

    import word_pkg::*;

    localparam int WW    = BYTE_W * NBYTES;
    localparam int IDX_W = (NBYTES > 1) ? $clog2(NBYTES) : 1;
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NBYTES - 1);

    state_t            r_state;
    state_t            w_stateNext;
    logic [IDX_W-1:0]  r_index;
    logic [IDX_W-1:0]  w_indexNext;
    logic [WW-1:0]     r_word;
    logic [WW-1:0]     w_wordNext;
    logic [WW-1:0]     w_shifted;
    logic              w_isLast;

    // Shifting the current byte up to the MSB end keeps the select width-clean.
    assign w_shifted = r_word << (r_index * BYTE_W);
    assign byte_out  = w_shifted[WW-1 -: BYTE_W];
    assign w_isLast  = (r_index == LAST_IDX);
    assign busy      = (r_state == SEND);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state <= IDLE;
            r_index <= '0;
            r_word  <= '0;
        end else begin
            r_state <= w_stateNext;
            r_index <= w_indexNext;
            r_word  <= w_wordNext;
        end
    end

    // The final-byte transfer doubles as the word-accept slot, giving zero-bubble back-to-back words.
    always_comb begin
        w_stateNext = r_state;
        w_indexNext = r_index;
        w_wordNext  = r_word;
        word_ready  = 1'b0;
        byte_valid  = 1'b0;
        case (r_state)
            IDLE: begin
                word_ready = 1'b1;
                if (word_valid) begin
                    w_wordNext  = word_in;
                    w_indexNext = '0;
                    w_stateNext = SEND;
                end
            end
            SEND: begin
                byte_valid = 1'b1;
                word_ready = w_isLast && byte_ready;
                if (byte_ready) begin
                    if (w_isLast) begin
                        if (word_valid) begin
                            w_wordNext  = word_in;
                            w_indexNext = '0;
                        end else begin
                            w_stateNext = IDLE;
                        end
                    end else begin
                        w_indexNext = r_index + 1'b1;
                    end
                end
            end
        endcase
    end

endmodule : unpack_channel

// File: rtl/word_unpacker.sv
// Two independent word-to-byte unpacking channels sharing only clock and reset.
module word_unpacker #(
    parameter int BYTE_W = word_pkg::BYTE_W,
    parameter int NBYTES = word_pkg::NBYTES
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic [BYTE_W*NBYTES-1:0] word_in_1,
    input  logic                     word_valid_1,
    output logic                     word_ready_1,
    output logic [BYTE_W-1:0]        byte_out_1,
    output logic                     byte_valid_1,
    input  logic                     byte_ready_1,
    input  logic [BYTE_W*NBYTES-1:0] word_in_2,
    input  logic                     word_valid_2,
    output logic                     word_ready_2,
    output logic [BYTE_W-1:0]        byte_out_2,
    output logic                     byte_valid_2,
    input  logic                     byte_ready_2,
    output logic [1:0]               busy
);

    logic w_busy1;
    logic w_busy2;

    unpack_channel #(.BYTE_W(BYTE_W), .NBYTES(NBYTES)) u_ch1 (
        .clk        (clk),
        .rst        (rst),
        .word_in    (word_in_1),
        .word_valid (word_valid_1),
        .word_ready (word_ready_1),
        .byte_out   (byte_out_1),
        .byte_valid (byte_valid_1),
        .byte_ready (byte_ready_1),
        .busy       (w_busy1)
    );

    unpack_channel #(.BYTE_W(BYTE_W), .NBYTES(NBYTES)) u_ch2 (
        .clk        (clk),
        .rst        (rst),
        .word_in    (word_in_2),
        .word_valid (word_valid_2),
        .word_ready (word_ready_2),
        .byte_out   (byte_out_2),
        .byte_valid (byte_valid_2),
        .byte_ready (byte_ready_2),
        .busy       (w_busy2)
    );

    assign busy = {w_busy2, w_busy1};

endmodule : word_unpacker

// File: tb/tb_word_unpacker.sv
// Directed self-checking bench for the dual-channel word unpacker.
module tb_word_unpacker;

    logic        clk;
    logic        rst;
    logic [31:0] wordIn1;
    logic        wordValid1;
    logic        wordReady1;
    logic [7:0]  byteOut1;
    logic        byteValid1;
    logic        byteReady1;
    logic [31:0] wordIn2;
    logic        wordValid2;
    logic        wordReady2;
    logic [7:0]  byteOut2;
    logic        byteValid2;
    logic        byteReady2;
    logic [1:0]  busy;

    int checks = 0;
    int errors = 0;

    word_unpacker dut (
        .clk          (clk),
        .rst          (rst),
        .word_in_1    (wordIn1),
        .word_valid_1 (wordValid1),
        .word_ready_1 (wordReady1),
        .byte_out_1   (byteOut1),
        .byte_valid_1 (byteValid1),
        .byte_ready_1 (byteReady1),
        .word_in_2    (wordIn2),
        .word_valid_2 (wordValid2),
        .word_ready_2 (wordReady2),
        .byte_out_2   (byteOut2),
        .byte_valid_2 (byteValid2),
        .byte_ready_2 (byteReady2),
        .busy         (busy)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Reset must hold both lanes idle even with words offered across a clock edge.
    task automatic test_reset();
        rst = 1'b0;
        wordIn1 = 32'h12345678; wordValid1 = 1'b1; byteReady1 = 1'b1;
        wordIn2 = 32'h9ABCDEF0; wordValid2 = 1'b1; byteReady2 = 1'b1;
        @(posedge clk);
        #1;
        checks++;
        if ({byteValid1, byteValid2, busy} !== 4'b0000) begin
            errors++;
            $display("[TB] FAIL reset_valid_busy got %b want 0000", {byteValid1, byteValid2, busy});
        end
        checks++;
        if ({byteOut1, byteOut2} !== 16'h0000) begin
            errors++;
            $display("[TB] FAIL reset_bytes got %h want 0000", {byteOut1, byteOut2});
        end
        checks++;
        if ({wordReady1, wordReady2} !== 2'b11) begin
            errors++;
            $display("[TB] FAIL reset_word_ready got %b want 11", {wordReady1, wordReady2});
        end
        @(negedge clk);
        wordValid1 = 1'b0; wordValid2 = 1'b0;
        rst = 1'b1;
        #1;
        checks++;
        if (busy !== 2'b00) begin
            errors++;
            $display("[TB] FAIL post_reset_busy got %b want 00", busy);
        end
    endtask

    task automatic test_single_word();
        logic [31:0] w = 32'hA1B2C3D4;
        @(negedge clk);
        wordIn1 = w; wordValid1 = 1'b1; byteReady1 = 1'b1;
        #1;
        checks++;
        if (wordReady1 !== 1'b1 || byteValid1 !== 1'b0) begin
            errors++;
            $display("[TB] FAIL single_idle ready/valid got %b%b want 10", wordReady1, byteValid1);
        end
        @(negedge clk);
        wordValid1 = 1'b0;
        for (int i = 0; i < 4; i++) begin
            #1;
            checks++;
            if (byteValid1 !== 1'b1 || byteOut1 !== w[31-8*i -: 8]) begin
                errors++;
                $display("[TB] FAIL single_byte%0d got v=%b %h want v=1 %h", i, byteValid1, byteOut1, w[31-8*i -: 8]);
            end
            checks++;
            if (wordReady1 !== (i == 3) || busy !== 2'b01) begin
                errors++;
                $display("[TB] FAIL single_ready%0d got rdy=%b busy=%b want rdy=%b busy=01", i, wordReady1, busy, (i == 3));
            end
            @(negedge clk);
        end
        #1;
        checks++;
        if (byteValid1 !== 1'b0 || busy !== 2'b00) begin
            errors++;
            $display("[TB] FAIL single_done got v=%b busy=%b want v=0 busy=00", byteValid1, busy);
        end
    endtask

    task automatic test_back_to_back();
        logic [63:0] stream = 64'h0102030405060708;
        @(negedge clk);
        wordIn1 = 32'h01020304; wordValid1 = 1'b1; byteReady1 = 1'b1;
        @(negedge clk);
        wordIn1 = 32'h05060708;
        for (int i = 0; i < 8; i++) begin
            if (i >= 4) wordValid1 = 1'b0;
            #1;
            checks++;
            if (byteValid1 !== 1'b1 || byteOut1 !== stream[63-8*i -: 8]) begin
                errors++;
                $display("[TB] FAIL b2b_byte%0d got v=%b %h want v=1 %h", i, byteValid1, byteOut1, stream[63-8*i -: 8]);
            end
            checks++;
            if (wordReady1 !== (i == 3 || i == 7)) begin
                errors++;
                $display("[TB] FAIL b2b_word_ready%0d got %b want %b", i, wordReady1, (i == 3 || i == 7));
            end
            @(negedge clk);
        end
        #1;
        checks++;
        if (byteValid1 !== 1'b0 || busy !== 2'b00) begin
            errors++;
            $display("[TB] FAIL b2b_done got v=%b busy=%b want v=0 busy=00", byteValid1, busy);
        end
    endtask

    // Ready pattern 1,0,0,1 repeats; each byte must hold until its accepting cycle.
    task automatic test_backpressure();
        logic [31:0] w = 32'hDEADBEEF;
        int idx = 0;
        @(negedge clk);
        wordIn2 = w; wordValid2 = 1'b1; byteReady2 = 1'b0;
        @(negedge clk);
        wordValid2 = 1'b0;
        for (int c = 0; c < 16 && idx < 4; c++) begin
            byteReady2 = (c % 4 == 0) || (c % 4 == 3);
            #1;
            checks++;
            if (byteValid2 !== 1'b1 || byteOut2 !== w[31-8*idx -: 8]) begin
                errors++;
                $display("[TB] FAIL bp_cycle%0d got v=%b %h want v=1 %h", c, byteValid2, byteOut2, w[31-8*idx -: 8]);
            end
            if (byteReady2) idx++;
            @(negedge clk);
        end
        byteReady2 = 1'b0;
        #1;
        checks++;
        if (idx !== 4 || byteValid2 !== 1'b0 || busy !== 2'b00) begin
            errors++;
            $display("[TB] FAIL bp_done got idx=%0d v=%b busy=%b want idx=4 v=0 busy=00", idx, byteValid2, busy);
        end
    endtask

    task automatic test_independence();
        logic [31:0] w1 = 32'h11223344;
        logic [31:0] w2 = 32'h55667788;
        @(negedge clk);
        wordIn1 = w1; wordValid1 = 1'b1; byteReady1 = 1'b1;
        wordIn2 = w2; wordValid2 = 1'b1; byteReady2 = 1'b0;
        @(negedge clk);
        wordValid1 = 1'b0; wordValid2 = 1'b0;
        for (int i = 0; i < 4; i++) begin
            #1;
            checks++;
            if (byteValid1 !== 1'b1 || byteOut1 !== w1[31-8*i -: 8]) begin
                errors++;
                $display("[TB] FAIL indep_ch1_byte%0d got v=%b %h want v=1 %h", i, byteValid1, byteOut1, w1[31-8*i -: 8]);
            end
            checks++;
            if (byteValid2 !== 1'b1 || byteOut2 !== 8'h55) begin
                errors++;
                $display("[TB] FAIL indep_ch2_hold%0d got v=%b %h want v=1 55", i, byteValid2, byteOut2);
            end
            @(negedge clk);
        end
        #1;
        checks++;
        if (busy !== 2'b10 || byteValid1 !== 1'b0 || byteOut2 !== 8'h55) begin
            errors++;
            $display("[TB] FAIL indep_state got busy=%b v1=%b b2=%h want busy=10 v1=0 b2=55", busy, byteValid1, byteOut2);
        end
        byteReady2 = 1'b1;
        for (int i = 0; i < 4; i++) begin
            #1;
            checks++;
            if (byteValid2 !== 1'b1 || byteOut2 !== w2[31-8*i -: 8]) begin
                errors++;
                $display("[TB] FAIL indep_ch2_drain%0d got v=%b %h want v=1 %h", i, byteValid2, byteOut2, w2[31-8*i -: 8]);
            end
            @(negedge clk);
        end
        #1;
        checks++;
        if (busy !== 2'b00) begin
            errors++;
            $display("[TB] FAIL indep_done got busy=%b want 00", busy);
        end
    endtask

    // Reset pulse lands between clock edges, so the drop must be asynchronous.
    task automatic test_reset_midword();
        logic [31:0] w = 32'hCAFEF00D;
        @(negedge clk);
        wordIn1 = w; wordValid1 = 1'b1; byteReady1 = 1'b1;
        @(negedge clk);
        wordValid1 = 1'b0;
        for (int i = 0; i < 2; i++) begin
            #1;
            checks++;
            if (byteOut1 !== w[31-8*i -: 8]) begin
                errors++;
                $display("[TB] FAIL rstmid_byte%0d got %h want %h", i, byteOut1, w[31-8*i -: 8]);
            end
            @(negedge clk);
        end
        #1;
        checks++;
        if (byteValid1 !== 1'b1 || byteOut1 !== 8'hF0) begin
            errors++;
            $display("[TB] FAIL rstmid_pre got v=%b %h want v=1 f0", byteValid1, byteOut1);
        end
        #1 rst = 1'b0;
        #1;
        checks++;
        if (byteValid1 !== 1'b0 || byteOut1 !== 8'h00 || busy !== 2'b00 || wordReady1 !== 1'b1) begin
            errors++;
            $display("[TB] FAIL rstmid_async got v=%b %h busy=%b rdy=%b want v=0 00 busy=00 rdy=1",
                     byteValid1, byteOut1, busy, wordReady1);
        end
        rst = 1'b1;
        wordIn1 = 32'h00000000; wordValid1 = 1'b1;
        @(negedge clk);
        wordValid1 = 1'b0;
        for (int i = 0; i < 4; i++) begin
            #1;
            checks++;
            if (byteValid1 !== 1'b1 || byteOut1 !== 8'h00) begin
                errors++;
                $display("[TB] FAIL rstmid_zero%0d got v=%b %h want v=1 00", i, byteValid1, byteOut1);
            end
            @(negedge clk);
        end
        #1;
        checks++;
        if (byteValid1 !== 1'b0 || busy !== 2'b00) begin
            errors++;
            $display("[TB] FAIL rstmid_done got v=%b busy=%b want v=0 busy=00", byteValid1, busy);
        end
    endtask

    initial begin
        rst = 1'b0;
        wordIn1 = '0; wordValid1 = 1'b0; byteReady1 = 1'b0;
        wordIn2 = '0; wordValid2 = 1'b0; byteReady2 = 1'b0;
        test_reset();
        test_single_word();
        test_back_to_back();
        test_backpressure();
        test_independence();
        test_reset_midword();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule : tb_word_unpacker
